// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point adder: word width,
// exception exponent and the stage-register record.
package fp_pkg;

  localparam int EXP_FW = 16;
  localparam int SIG_FW = 64;

  function automatic int fp_width(input int expW, input int manW);
    return 1 + expW + manW;
  endfunction

  // All-ones exponent of the given width, marking infinities/NaNs and overflow.
  function automatic logic [EXP_FW-1:0] fp_exc_exp(input int expW);
    return EXP_FW'((32'd1 << expW) - 32'd1);
  endfunction

  // Fields are sized for the widest supported format; narrower instances use the low bits.
  typedef struct packed {
    logic              valid;
    logic              sign;
    logic [EXP_FW-1:0] exponent;
    logic [SIG_FW-1:0] significand;
    logic              overflow;
  } fp_stage_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
  parameter int WIDTH = 24,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value_i,
  output logic [CNT_W-1:0] count_o
);

  always_comb begin
    count_o = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value_i[i]) count_o = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_pipe_adder.sv
// Three-stage floating-point adder/subtractor (align, add, normalise) with a
// single global advance so all stages move together under backpressure.
module fp_pipe_adder
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = fp_width(EXP_W, MAN_W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] S,
  output logic         Overflow
);

  localparam int SIG_W = MAN_W + 1;
  localparam int SUM_W = MAN_W + 2;
  localparam int XE_W  = EXP_W + 2;
  localparam int CNT_W = $clog2(SIG_W + 1);
  localparam logic [EXP_W-1:0] EXC_EXP = EXP_W'(fp_exc_exp(EXP_W));

  fp_stage_t        s1_q, s1_d, s2_q, s2_d;
  logic [SIG_W-1:0] s1Small_q, s1Small_d;
  logic             s1Sub_q, s1Sub_d, s2Sub_q, s2Sub_d;
  logic             outValid_q, outOvf_q, outOvf_d;
  logic [W-1:0]     outS_q, outS_d;
  logic             advance;

  logic [EXP_W-1:0] expA, expB, bigExp, smallExp, shift;
  logic [SIG_W-1:0] sigA, sigB, bigSig, smallSig, bigSig2;
  logic             signB, aBig, bigSign, smallSign;
  logic [SUM_W-1:0] sum2, sum3;
  logic [CNT_W-1:0] lzCount;
  logic [SIG_W-1:0] normSig;
  logic signed [XE_W-1:0] expX, normExp;

  assign advance   = !outValid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = outValid_q;
  assign S         = outS_q;
  assign Overflow  = outOvf_q;

  // Unpack with denormal flush, order operands by magnitude, align the smaller one.
  always_comb begin
    expA      = a[W-2 -: EXP_W];
    expB      = b[W-2 -: EXP_W];
    sigA      = (expA == '0) ? '0 : {1'b1, a[MAN_W-1:0]};
    sigB      = (expB == '0) ? '0 : {1'b1, b[MAN_W-1:0]};
    signB     = b[W-1] ^ op;
    aBig      = {expA, sigA} >= {expB, sigB};
    bigExp    = aBig ? expA : expB;
    smallExp  = aBig ? expB : expA;
    bigSig    = aBig ? sigA : sigB;
    smallSig  = aBig ? sigB : sigA;
    bigSign   = aBig ? a[W-1] : signB;
    smallSign = aBig ? signB : a[W-1];
    shift     = bigExp - smallExp;

    s1_d             = '0;
    s1_d.valid       = in_valid;
    s1_d.sign        = bigSign;
    s1_d.exponent    = EXP_FW'(bigExp);
    s1_d.significand = SIG_FW'(bigSig);
    s1_d.overflow    = (expA == EXC_EXP) || (expB == EXC_EXP);
    s1Small_d        = (int'(shift) >= MAN_W + 2) ? '0 : (smallSig >> shift);
    s1Sub_d          = bigSign ^ smallSign;
  end

  always_comb begin
    bigSig2          = s1_q.significand[SIG_W-1:0];
    sum2             = s1Sub_q ? ({1'b0, bigSig2} - {1'b0, s1Small_q})
                               : ({1'b0, bigSig2} + {1'b0, s1Small_q});
    s2_d             = s1_q;
    s2_d.significand = SIG_FW'(sum2);
    s2Sub_d          = s1Sub_q;
  end

  fp_lzc #(.WIDTH(SIG_W)) u_lzc (
    .value_i (sum3[SIG_W-1:0]),
    .count_o (lzCount)
  );

  // Normalise, then pick between exact zero, underflow, exponent overflow and a normal pack.
  always_comb begin
    sum3 = s2_q.significand[SUM_W-1:0];
    expX = $signed({2'b00, s2_q.exponent[EXP_W-1:0]});
    if (sum3[SUM_W-1]) begin
      normSig = sum3[SUM_W-1:1];
      normExp = expX + XE_W'(1);
    end else begin
      normSig = sum3[SIG_W-1:0] << lzCount;
      normExp = expX - XE_W'(lzCount);
    end

    outOvf_d = s2_q.overflow;
    if (sum3 == '0) begin
      outS_d = {s2Sub_q | s2_q.sign, {(W-1){1'b0}}};
    end else if (normExp[XE_W-1] || normExp == '0) begin
      outS_d = {s2_q.sign, {(W-1){1'b0}}};
    end else if (normExp >= $signed({2'b00, EXC_EXP})) begin
      outS_d   = {s2_q.sign, EXC_EXP, {MAN_W{1'b0}}};
      outOvf_d = 1'b1;
    end else begin
      outS_d = {s2_q.sign, normExp[EXP_W-1:0], normSig[MAN_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s1Small_q  <= '0;
      s1Sub_q    <= 1'b0;
      s2_q       <= '0;
      s2Sub_q    <= 1'b0;
      outValid_q <= 1'b0;
      outS_q     <= '0;
      outOvf_q   <= 1'b0;
    end else if (advance) begin
      s1_q       <= s1_d;
      s1Small_q  <= s1Small_d;
      s1Sub_q    <= s1Sub_d;
      s2_q       <= s2_d;
      s2Sub_q    <= s2Sub_d;
      outValid_q <= s2_q.valid;
      outS_q     <= outS_d;
      outOvf_q   <= outOvf_d;
    end
  end

endmodule

// File: tb/tb_fp_pipe_adder.sv
// Scoreboard bench for fp_pipe_adder: single-precision and half-precision
// instances driven with hand-computed directed vectors.
module tb_fp_pipe_adder;

  typedef struct {
    logic [31:0] s;
    logic        ovf;
    logic        careS;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, op, out_valid, out_ready, Overflow;
  logic [31:0] a, b, S;
  logic        hIn_valid, hIn_ready, hOp, hOut_valid, hOut_ready, hOverflow;
  logic [15:0] hA, hB, hS;

  exp_t expQ[$];
  exp_t hExpQ[$];
  int   checkCount = 0;
  int   errCount = 0;
  int   acceptCount = 0;
  int   resultCount = 0;
  int   base;

  fp_pipe_adder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Overflow(Overflow)
  );

  fp_pipe_adder #(.EXP_W(5), .MAN_W(10)) dutHalf (
    .clk(clk), .rst(rst), .in_valid(hIn_valid), .in_ready(hIn_ready),
    .a(hA), .b(hB), .op(hOp), .out_valid(hOut_valid), .out_ready(hOut_ready),
    .S(hS), .Overflow(hOverflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input exp_t e, input logic [31:0] gotS, input logic gotOvf,
                             input string tag);
    checkCount++;
    if (gotOvf !== e.ovf || (e.careS && gotS !== e.s)) begin
      errCount++;
      $display("[TB] FAIL %s/%s: got S=%h Overflow=%b, required S=%h Overflow=%b",
               e.name, tag, gotS, gotOvf, e.s, e.ovf);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
    checkCount++;
    if (got !== want) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  // Caller is just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input bit half, input string name, input logic [31:0] aV,
                               input logic [31:0] bV, input logic opV, input logic [31:0] sV,
                               input logic ovfV, input logic careV);
    int waited = 0;
    bit accepted = 1'b0;
    if (half) begin
      hA = aV[15:0]; hB = bV[15:0]; hOp = opV; hIn_valid = 1'b1;
    end else begin
      a = aV; b = bV; op = opV; in_valid = 1'b1;
    end
    while (!accepted && waited < 100) begin
      @(negedge clk);
      if (half ? hIn_ready : in_ready) accepted = 1'b1;
      else waited++;
    end
    if (accepted) begin
      if (half) hExpQ.push_back('{sV, ovfV, careV, name});
      else expQ.push_back('{sV, ovfV, careV, name});
      acceptCount++;
    end else begin
      checkCount++;
      errCount++;
      $display("[TB] FAIL %s accept_timeout: in_ready=0, required 1", name);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    hIn_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((expQ.size() != 0 || hExpQ.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    checkCount++;
    if (expQ.size() != 0 || hExpQ.size() != 0) begin
      errCount++;
      $display("[TB] FAIL %s_drain: %0d results pending, required 0", name,
               expQ.size() + hExpQ.size());
    end
    #1;
  endtask

  // Monitors: compare the queue head whenever a result is presented, pop on delivery.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (expQ.size() == 0) begin
        checkCount++;
        errCount++;
        $display("[TB] FAIL unexpected_result: got S=%h, required no output", S);
      end else begin
        checkOutput(expQ[0], S, Overflow, out_ready ? "deliver" : "stall");
      end
      if (out_ready) begin
        resultCount++;
        if (expQ.size() != 0) void'(expQ.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && hOut_valid) begin
      if (hExpQ.size() == 0) begin
        checkCount++;
        errCount++;
        $display("[TB] FAIL unexpected_half_result: got S=%h, required no output", hS);
      end else begin
        checkOutput(hExpQ[0], {16'h0, hS}, hOverflow, "half");
      end
      if (hOut_ready && hExpQ.size() != 0) void'(hExpQ.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b1;
    hIn_valid = 1'b0; hA = '0; hB = '0; hOp = 1'b0; hOut_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset_out_valid", 32'(out_valid), 32'd0);
    checkValue("reset_S", S, 32'd0);
    checkValue("reset_Overflow", 32'(Overflow), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkValue("ready_after_reset", 32'(in_ready), 32'd1);

    applyStimulus(0, "neg_add",     32'hC2340000, 32'hC2340000, 0, 32'hC2B40000, 0, 1);
    applyStimulus(0, "cancel",      32'h40000000, 32'h40000000, 1, 32'h80000000, 0, 1);
    applyStimulus(0, "mixed_exp",   32'h3FE5B22D, 32'h42C7908A, 0, 32'h42CB2752, 0, 1);
    applyStimulus(0, "operand_exc", 32'hFFE872B0, 32'h42340000, 0, 32'h00000000, 1, 0);
    applyStimulus(0, "exp_ovf",     32'h7F000000, 32'h7F000000, 0, 32'h7F800000, 1, 1);
    applyStimulus(0, "sub_half",    32'h3F800000, 32'h3F000000, 1, 32'h3F000000, 0, 1);
    applyStimulus(0, "sub_neg",     32'h3F000000, 32'h3F800000, 1, 32'hBF000000, 0, 1);
    applyStimulus(0, "far_shift",   32'h3F800000, 32'h30800000, 0, 32'h3F800000, 0, 1);
    applyStimulus(0, "denorm_in",   32'h00400000, 32'h3F800000, 0, 32'h3F800000, 0, 1);
    applyStimulus(0, "underflow",   32'h80800000, 32'h00C00000, 0, 32'h00000000, 0, 1);
    applyStimulus(0, "carry",       32'h40400000, 32'h3F800000, 0, 32'h40800000, 0, 1);
    applyStimulus(0, "trunc_carry", 32'h3F800001, 32'h3F800000, 0, 32'h40000000, 0, 1);
    applyStimulus(0, "trunc_sub",   32'h3F800000, 32'h33800000, 1, 32'h3F800000, 0, 1);
    waitDrain("directed");

    // Backpressure: five ops issued while the consumer is stalled.
    out_ready = 1'b0;
    acceptCount = 0;
    base = resultCount;
    fork
      begin
        applyStimulus(0, "bp0", 32'h3F800000, 32'h3F800000, 0, 32'h40000000, 0, 1);
        applyStimulus(0, "bp1", 32'h40000000, 32'h40000000, 0, 32'h40800000, 0, 1);
        applyStimulus(0, "bp2", 32'h3F800000, 32'h40000000, 0, 32'h40400000, 0, 1);
        applyStimulus(0, "bp3", 32'h40800000, 32'h40800000, 0, 32'h41000000, 0, 1);
        applyStimulus(0, "bp4", 32'h41000000, 32'h40800000, 1, 32'h40800000, 0, 1);
      end
      begin
        int n = 0;
        while (acceptCount < 3 && n < 50) begin
          @(negedge clk);
          n++;
        end
        @(negedge clk);
        checkValue("bp_in_ready_low", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        checkValue("bp_accepts_held", acceptCount, 32'd3);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain("backpressure");
    checkValue("bp_result_count", resultCount - base, 32'd5);

    // Reset with two operations in flight.
    applyStimulus(0, "stale0", 32'h3F800000, 32'h3F800000, 0, 32'h40000000, 0, 1);
    applyStimulus(0, "stale1", 32'h40000000, 32'h40000000, 0, 32'h40800000, 0, 1);
    rst = 1'b1;
    expQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkValue("rst_flush_out_valid", 32'(out_valid), 32'd0);
    base = resultCount;
    repeat (6) @(posedge clk);
    #1;
    checkValue("rst_no_stale", resultCount, base);

    applyStimulus(1, "half_add",    32'h3C00, 32'h3C00, 0, 32'h4000, 0, 1);
    applyStimulus(1, "half_cancel", 32'h3C00, 32'h3C00, 1, 32'h8000, 0, 1);
    applyStimulus(1, "half_ovf",    32'h7BFF, 32'h7BFF, 0, 32'h7C00, 1, 1);
    waitDrain("half");

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fp_pipe_adder.md
FP_PIPE_ADDER -- requirements
Module: fp_pipe_adder

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, stored-mantissa width (total word width W = 1+EXP_W+MAN_W).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair a/b/op presented.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  W  IEEE-style operand A.
REQ-008 SHALL have port b  input  W  IEEE-style operand B.
REQ-009 SHALL have port op  input  1  0 = a+b, 1 = a-b (invert b sign at input).
REQ-010 SHALL have port out_valid  output  1  S/Overflow hold a result.
REQ-011 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-012 SHALL have port S  output  W  sum.
REQ-013 SHALL have port Overflow  output  1  result or operand out of range.

Function
REQ-014 SHALL implement a 3-stage pipeline: S1 unpack/compare/align, S2 significand add/sub, S3 normalise/pack; latency exactly 3 cycles from accept to out_valid with no stall.
REQ-015 SHALL accept a transfer when in_valid && in_ready; SHALL deliver when out_valid && out_ready.
REQ-016 SHALL drive in_ready = !out_valid || out_ready (global advance); on advance all stages shift together, bubbles propagate as valid=0.
REQ-017 SHALL hold S, Overflow and out_valid stable while out_valid && !out_ready.
REQ-018 SHALL sustain throughput of one result per cycle when out_ready is held high.
REQ-019 SHALL align by right-shifting the smaller-exponent significand (hidden 1 restored); shift >= MAN_W+2 yields zero contribution.
REQ-020 SHALL round by truncation (bits shifted out discarded).
REQ-021 SHALL, on effective subtraction, subtract smaller magnitude from larger; result sign = sign of larger-magnitude operand.
REQ-022 SHALL produce exact cancellation as sign 1, exponent 0, mantissa 0.
REQ-023 SHALL normalise via leading-zero count and left shift, or one-bit right shift with exponent+1 on carry-out.
REQ-024 SHALL flush denormal inputs (exponent 0) to zero and flush results with exponent underflow (<=0) to signed zero, Overflow=0.
REQ-025 SHALL set Overflow=1 and S = sign, all-ones exponent, zero mantissa when the result exponent reaches all-ones.
REQ-026 SHALL set Overflow=1 when either input has an all-ones exponent; S is then don't-care.
REQ-027 SHALL carry Overflow through the pipeline aligned with its result.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, clear all stage valid bits; out_valid=0, S=0, Overflow=0 after that edge.
REQ-029 SHALL discard in-flight operations on reset mid-operation; no partial result emerges afterwards.
REQ-030 SHALL drive in_ready=1 from the first cycle after reset.

Structure
REQ-031 SHALL place W calculation, stage-register record typedef (valid, sign, exponent, significand, overflow) and the exception exponent constant in shared package fp_pkg.
REQ-032 SHALL implement leading-zero count in one sub-module fp_lzc, parametrised on width.

Verification
REQ-033 a=0xC2340000 (-45), b=0xC2340000, op=0 -> S=0xC2B40000, Overflow=0, 3 cycles later.
REQ-034 a=0x40000000, b=0x40000000, op=1 -> S=0x80000000, Overflow=0.
REQ-035 a=0x3FE5B22D, b=0x42C7908A, op=0 -> S=0x42CB2752, Overflow=0.
REQ-036 a=0xFFE872B0, b=0x42340000 -> Overflow=1; a=0x7F000000, b=0x7F000000 -> S=0x7F800000, Overflow=1.
REQ-037 Issue 5 back-to-back ops with out_ready=0 -> in_ready falls after 3 accepts; release out_ready -> all 5 results in order, none lost or duplicated; assert rst with 2 in flight -> out_valid=0 and no stale results.
REQ-038 EXP_W=5, MAN_W=10: a=0x3C00, b=0x3C00, op=0 -> S=0x4000, Overflow=0.
